// File: rtl/btn_pkg.sv
// Shared types and event codes for the button event controller.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESSED = 2'b01,
        LONG    = 2'b10
    } btn_state_t;

    localparam logic [1:0] EV_NONE    = 2'b00;
    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_LONG    = 2'b11;

endpackage

// File: rtl/event_latch.sv
// Single-entry pending event register with ack and sticky overrun.
module event_latch
    import btn_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       post,
    input  logic [1:0] code,
    input  logic       ack,
    output logic       pending,
    output logic [1:0] event_code,
    output logic       overrun
);

    always_ff @(posedge clock) begin
        if (reset) begin
            pending    <= 1'b0;
            event_code <= EV_NONE;
            overrun    <= 1'b0;
        end else if (post) begin
            // An ack in the same cycle frees the slot for the new event.
            if (!pending || ack) begin
                pending    <= 1'b1;
                event_code <= code;
            end else begin
                overrun <= 1'b1;
            end
        end else if (ack) begin
            pending    <= 1'b0;
            event_code <= EV_NONE;
        end
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Press / release / long-press detector feeding a pending-event latch.
module button_event_ctrl
    import btn_pkg::*;
#(
    parameter int LONG_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_db,
    input  logic       irq_ack,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       irq,
    output logic [1:0] event_code,
    output logic       overrun
);

    localparam int CW = $clog2(LONG_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(LONG_CYCLES - 1);

    logic          btn_q;
    logic          rise;
    logic          fall;
    btn_state_t    state;
    btn_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          press_nxt;
    logic          release_nxt;
    logic          long_nxt;
    logic          post;
    logic [1:0]    post_code;
    logic          pending;

    assign rise = btn_db & ~btn_q;
    assign fall = ~btn_db & btn_q;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else if (cnt == LAST) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Events post on the same edge that registers their pulse.
    always_comb begin
        post      = press_nxt | release_nxt | long_nxt;
        post_code = EV_NONE;
        if (press_nxt)
            post_code = EV_PRESS;
        else if (release_nxt)
            post_code = EV_RELEASE;
        else if (long_nxt)
            post_code = EV_LONG;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_q         <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            btn_q         <= btn_db;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
        end
    end

    event_latch u_latch (
        .clock      (clock),
        .reset      (reset),
        .post       (post),
        .code       (post_code),
        .ack        (irq_ack),
        .pending    (pending),
        .event_code (event_code),
        .overrun    (overrun)
    );

    assign irq = pending;

endmodule
